mul_req_ctrl: RTL and testbench
===============================

Name: mul_req_ctrl

Overview:
Execute-stage requester for the M-extension multiplier; the initiator side of its valid/ready request and response handshake.
- Accepts a decoded MUL/MULH/MULHSU/MULHU instruction from the pipeline and registers its operands.
- Drives the multiplier request channel, holds the response channel ready, captures the 32-bit result and emits a one-cycle writeback pulse.
- Stalls the pipeline while a multiply is outstanding and handles flush mid-operation.

Parameters:
XLEN, 32, operand/result width
REG_AW, 5, destination register address width
TIMEOUT_CYCLES, 16, max cycles in WAIT before timeout (used only with MUL_REQ_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid_i  in  1  decoded M-instruction present
ex_ready_o  out  1  block can accept instruction (state==IDLE)
ex_op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
ex_rs1_i  in  XLEN  operand a
ex_rs2_i  in  XLEN  operand b
ex_rd_i  in  REG_AW  destination register
flush_i  in  1  kill in-flight instruction
mul_valid_o  out  1  request valid to multiplier
mul_ready_i  in  1  multiplier can accept request
mul_a_o, mul_b_o  out  XLEN  registered operands
mul_op_o  out  2  registered op; stable from capture until leaving WAIT
mul_rsp_valid_i  in  1  multiplier result valid (may be a single-cycle pulse)
mul_rsp_ready_o  out  1  response ready
mul_result_i  in  XLEN  multiplier result
wb_valid_o  out  1  one-cycle writeback strobe
wb_rd_o  out  REG_AW  writeback register
wb_data_o  out  XLEN  writeback data
timeout_err_o  out  1  timeout pulse; tied 0 without macro

Behaviour:
- FSM states: IDLE, REQ, WAIT, WB.
- Reset values:
  - State IDLE.
  - mul_valid_o, mul_rsp_ready_o, wb_valid_o and timeout_err_o are 0.
  - Operand, op, rd and data registers are 0.
  - ex_ready_o is 1, since it is decoded from IDLE.
- IDLE:
  - ex_ready_o=1.
  - On ex_valid_i, capture rs1/rs2/op/rd, then go to REQ. flush_i has no effect in IDLE.
- REQ:
  - mul_valid_o=1.
  - On mul_ready_i, go to WAIT; the request is accepted in that cycle.
  - On flush_i without mul_ready_i in the same cycle, go to IDLE with no request issued.
  - On flush_i together with mul_ready_i, the request is accepted; set the kill flag and go to WAIT.
- WAIT:
  - mul_rsp_ready_o=1 continuously. The responder's valid is not guaranteed to persist, so ready is never deasserted while waiting.
  - On mul_rsp_valid_i, latch mul_result_i into wb_data_o.
  - With kill clear, go to WB. With kill set, go to IDLE and clear kill.
  - flush_i in WAIT sets kill. It never abandons WAIT, because the multiplier is still busy.
- WB:
  - wb_valid_o=1 for exactly one cycle, with wb_rd_o and wb_data_o stable.
  - Unconditionally return to IDLE. No backpressure.
  - flush_i in WB is ignored, because the instruction is already committed.
- Latency (no stalls):
  - ex accept at cycle N; mul_valid_o at N+1.
  - Response at cycle M gives wb_valid_o at M+1.
  - Next ex_ready_o is at M+2.
- mul_a_o, mul_b_o and mul_op_o come only from registers and never change between capture and exit from WAIT.
- Asynchronous reset mid-operation returns to IDLE. A response arriving later is ignored, because mul_rsp_ready_o is 0 outside WAIT.
- mul_rsp_valid_i outside WAIT is ignored. wb_valid_o never asserts without a prior WAIT response.

Optional Feature:
MUL_REQ_TIMEOUT_EN:
- Defined:
  - A cycle counter resets on WAIT entry and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no mul_rsp_valid_i, timeout_err_o pulses for 1 cycle and the FSM goes to IDLE.
  - There is no writeback and kill is cleared.
  - A response in the same cycle as the expiry wins; normal WB follows and there is no error.
- Undefined: no counter; WAIT persists indefinitely; timeout_err_o is tied to 0.

Decomposition:
- Package mul_req_pkg holds:
  - mul_op_e: MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11.
  - mul_req_state_e: IDLE, REQ, WAIT, WB.
  - XLEN and REG_AW default constants.
- No sub-module; the FSM, registers and optional counter stay in a single module.

Test Plan:
1. MUL, rs1=7, rs2=6, rd=5, multiplier model with 1-cycle response -> one wb_valid_o pulse, wb_rd_o=5, wb_data_o=42, latency as specified.
2. MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, mul_ready_i held low 3 cycles -> mul_valid_o and operands stable for all 3 cycles; wb_data_o=0xFFFFFFFE.
3. Model drives a single-cycle mul_rsp_valid_i pulse 5 cycles after accept -> captured; mul_rsp_ready_o high throughout WAIT; ex_ready_o low from accept until WB exit.
4. flush_i in REQ before ready -> IDLE, no request handshake, no wb. flush_i in WAIT -> response consumed, no wb_valid_o, back to IDLE.
5. Reset asserted in WAIT, then a late response pulse -> ignored; all outputs at reset values; a new MUL 3*3 writes back 9.
6. MUL_REQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and no response -> timeout_err_o pulses once after 16 WAIT cycles, no wb, IDLE. Response exactly on cycle 16 -> normal wb, no error.

Source files
------------

// File: rtl/mul_req_pkg.sv
// rtl/mul_req_pkg.sv - shared opcode/state types and default widths for the M-extension multiplier requester
package mul_req_pkg;

  localparam int unsigned XLEN_DEFAULT           = 32;
  localparam int unsigned REG_AW_DEFAULT         = 5;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    WB   = 2'b11
  } mul_req_state_e;

endpackage

// File: rtl/mul_req_ctrl.sv
// rtl/mul_req_ctrl.sv - execute-stage multiplier requester FSM; MUL_REQ_TIMEOUT_EN adds a WAIT watchdog
module mul_req_ctrl
  import mul_req_pkg::*;
#(
  parameter int unsigned XLEN           = XLEN_DEFAULT,
  parameter int unsigned REG_AW         = REG_AW_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [1:0]        ex_op_i,
  input  logic [XLEN-1:0]   ex_rs1_i,
  input  logic [XLEN-1:0]   ex_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              flush_i,
  output logic              mul_valid_o,
  input  logic              mul_ready_i,
  output logic [XLEN-1:0]   mul_a_o,
  output logic [XLEN-1:0]   mul_b_o,
  output logic [1:0]        mul_op_o,
  input  logic              mul_rsp_valid_i,
  output logic              mul_rsp_ready_o,
  input  logic [XLEN-1:0]   mul_result_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              timeout_err_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mul_req_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  mul_req_state_e    r_state;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  mul_op_e           r_op;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_data;
  logic              r_kill;
  logic              w_kill_now;
  logic              w_timeout;

  // A flush arriving together with the response still squashes the writeback.
  assign w_kill_now = r_kill | flush_i;

`ifdef MUL_REQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  // Expiry on the TIMEOUT_CYCLES-th WAIT cycle; a response in that same cycle wins.
  assign w_timeout = (r_state == WAIT) && !mul_rsp_valid_i &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (r_state != WAIT) begin
        r_cnt <= '0;
      end else if (!w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign timeout_err_o = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= MUL;
      r_rd    <= '0;
      r_data  <= '0;
      r_kill  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_valid_i) begin
            r_a     <= ex_rs1_i;
            r_b     <= ex_rs2_i;
            r_op    <= mul_op_e'(ex_op_i);
            r_rd    <= ex_rd_i;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mul_ready_i) begin
            r_kill  <= flush_i;
            r_state <= WAIT;
          end else if (flush_i) begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          // The multiplier is busy once the request is accepted, so WAIT only exits on a response or timeout.
          if (mul_rsp_valid_i) begin
            r_data  <= mul_result_i;
            r_kill  <= 1'b0;
            r_state <= w_kill_now ? IDLE : WB;
          end else if (w_timeout) begin
            r_kill  <= 1'b0;
            r_state <= IDLE;
          end else if (flush_i) begin
            r_kill  <= 1'b1;
          end
        end
        WB: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ex_ready_o      = (r_state == IDLE);
  assign mul_valid_o     = (r_state == REQ);
  assign mul_rsp_ready_o = (r_state == WAIT);
  assign wb_valid_o      = (r_state == WB);
  assign mul_a_o         = r_a;
  assign mul_b_o         = r_b;
  assign mul_op_o        = r_op;
  assign wb_rd_o         = r_rd;
  assign wb_data_o       = r_data;

endmodule

// File: tb/tb_mul_req_ctrl.sv
// tb/tb_mul_req_ctrl.sv - self-checking bench for mul_req_ctrl with a behavioural multiplier model
module tb_mul_req_ctrl;
  import mul_req_pkg::*;

  localparam int XW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ex_valid_i = 1'b0;
  logic          ex_ready_o;
  logic [1:0]    ex_op_i = 2'b00;
  logic [XW-1:0] ex_rs1_i = '0;
  logic [XW-1:0] ex_rs2_i = '0;
  logic [AW-1:0] ex_rd_i = '0;
  logic          flush_i = 1'b0;
  logic          mul_valid_o;
  logic          mul_ready_i = 1'b0;
  logic [XW-1:0] mul_a_o;
  logic [XW-1:0] mul_b_o;
  logic [1:0]    mul_op_o;
  logic          mul_rsp_valid_i = 1'b0;
  logic          mul_rsp_ready_o;
  logic [XW-1:0] mul_result_i = '0;
  logic          wb_valid_o;
  logic [AW-1:0] wb_rd_o;
  logic [XW-1:0] wb_data_o;
  logic          timeout_err_o;

  mul_req_ctrl #(.XLEN(XW), .REG_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_op_i(ex_op_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_op_o(mul_op_o),
    .mul_rsp_valid_i(mul_rsp_valid_i), .mul_rsp_ready_o(mul_rsp_ready_o),
    .mul_result_i(mul_result_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wb_seen = 0;
  int wb_exp = 0;
  int to_seen = 0;
  int to_exp = 0;

  always @(negedge clk) begin
    if (wb_valid_o) wb_seen++;
    if (timeout_err_o) to_seen++;
  end

  typedef struct {
    logic [1:0]    op;
    logic [XW-1:0] a;
    logic [XW-1:0] b;
    logic [AW-1:0] rd;
    int            rdy_dly;
    int            rsp_dly;
    logic [XW-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural RV32M result from full 64-bit products.
  function automatic logic [XW-1:0] mul_ref(input logic [1:0] op, input logic [XW-1:0] a,
                                            input logic [XW-1:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00:   begin p = ua * ub; return p[31:0];  end
      2'b01:   begin p = sa * sb; return p[63:32]; end
      2'b10:   begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  task automatic accept(input logic [1:0] op, input logic [XW-1:0] a, input logic [XW-1:0] b,
                        input logic [AW-1:0] rd);
    chk("ex_ready_idle", ex_ready_o, 1);
    ex_valid_i = 1'b1; ex_op_i = op; ex_rs1_i = a; ex_rs2_i = b; ex_rd_i = rd;
    step();
    ex_valid_i = 1'b0;
    ex_op_i = 2'($urandom); ex_rs1_i = $urandom; ex_rs2_i = $urandom; ex_rd_i = 5'($urandom);
    chk("req_valid_n1", mul_valid_o, 1);
    chk("req_ex_ready_low", ex_ready_o, 0);
  endtask

  task automatic go_wait(input logic [1:0] op, input logic [XW-1:0] a, input logic [XW-1:0] b,
                         input logic [AW-1:0] rd);
    accept(op, a, b, rd);
    mul_ready_i = 1'b1;
    step();
    mul_ready_i = 1'b0;
    chk("wait_rsp_ready", mul_rsp_ready_o, 1);
  endtask

  task automatic run_txn(input vec_t v);
    accept(v.op, v.a, v.b, v.rd);
    for (int i = 0; i <= v.rdy_dly; i++) begin
      chk("req_valid_hold", mul_valid_o, 1);
      chk("req_a_stable", mul_a_o, v.a);
      chk("req_b_stable", mul_b_o, v.b);
      chk("req_op_stable", mul_op_o, v.op);
      if (i < v.rdy_dly) step();
    end
    mul_ready_i = 1'b1;
    step();
    mul_ready_i = 1'b0;
    for (int i = 0; i <= v.rsp_dly; i++) begin
      chk("wait_rsp_ready", mul_rsp_ready_o, 1);
      chk("wait_no_req", mul_valid_o, 0);
      chk("wait_no_wb", wb_valid_o, 0);
      chk("wait_ex_ready_low", ex_ready_o, 0);
      chk("wait_op_stable", mul_op_o, v.op);
      if (i < v.rsp_dly) step();
    end
    mul_rsp_valid_i = 1'b1;
    mul_result_i = mul_ref(v.op, v.a, v.b);
    step();
    mul_rsp_valid_i = 1'b0;
    mul_result_i = $urandom;
    wb_exp++;
    chk("wb_valid", wb_valid_o, 1);
    chk("wb_rd", wb_rd_o, v.rd);
    chk("wb_data", wb_data_o, v.exp);
    chk("wb_ex_ready_low", ex_ready_o, 0);
    chk("wb_rsp_ready_low", mul_rsp_ready_o, 0);
    step();
    chk("post_wb_valid_low", wb_valid_o, 0);
    chk("post_wb_ex_ready", ex_ready_o, 1);
    chk("post_wb_data_hold", wb_data_o, v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{op: 2'b00, a: 32'd7,        b: 32'd6,        rd: 5'd5,  rdy_dly: 0, rsp_dly: 0, exp: 32'd42};
    vecs[1] = '{op: 2'b11, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, rd: 5'd9,  rdy_dly: 3, rsp_dly: 0, exp: 32'hFFFFFFFE};
    vecs[2] = '{op: 2'b00, a: 32'd100,      b: 32'd200,      rd: 5'd17, rdy_dly: 0, rsp_dly: 3, exp: 32'd20000};
    vecs[3] = '{op: 2'b01, a: 32'hFFFFFFFE, b: 32'd3,        rd: 5'd1,  rdy_dly: 1, rsp_dly: 2, exp: 32'hFFFFFFFF};
    vecs[4] = '{op: 2'b10, a: 32'hFFFFFFFF, b: 32'd2,        rd: 5'd31, rdy_dly: 2, rsp_dly: 1, exp: 32'hFFFFFFFF};
    vecs[5] = '{op: 2'b01, a: 32'h80000000, b: 32'h80000000, rd: 5'd0,  rdy_dly: 0, rsp_dly: 4, exp: 32'h40000000};

    repeat (2) step();
    chk("rst_ex_ready", ex_ready_o, 1);
    chk("rst_mul_valid", mul_valid_o, 0);
    chk("rst_rsp_ready", mul_rsp_ready_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_timeout", timeout_err_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_mul_a", mul_a_o, 0);
    chk("rst_mul_op", mul_op_o, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    for (int i = 0; i < 16; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a = $urandom;
      v.b = $urandom;
      v.rd = 5'($urandom);
      v.rdy_dly = $urandom_range(0, 3);
      v.rsp_dly = $urandom_range(0, 6);
      v.exp = mul_ref(v.op, v.a, v.b);
      run_txn(v);
    end

    // flush in REQ before ready: dropped with no handshake
    accept(2'b00, 32'd11, 32'd12, 5'd4);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_req_no_valid", mul_valid_o, 0);
    chk("flush_req_idle", ex_ready_o, 1);
    chk("flush_req_no_rsp_ready", mul_rsp_ready_o, 0);
    step();
    chk("flush_req_no_wb", wb_valid_o, 0);

    // flush in WAIT: stays until response, then IDLE with no writeback
    go_wait(2'b00, 32'd5, 32'd5, 5'd3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_wait_stays", mul_rsp_ready_o, 1);
    step();
    chk("flush_wait_stays2", mul_rsp_ready_o, 1);
    mul_rsp_valid_i = 1'b1; mul_result_i = 32'd25;
    step();
    mul_rsp_valid_i = 1'b0;
    chk("flush_wait_no_wb", wb_valid_o, 0);
    chk("flush_wait_idle", ex_ready_o, 1);
    chk("flush_wait_data", wb_data_o, 25);

    // flush together with ready in REQ: request accepted, result squashed
    accept(2'b11, 32'd2, 32'd3, 5'd6);
    mul_ready_i = 1'b1; flush_i = 1'b1;
    step();
    mul_ready_i = 1'b0; flush_i = 1'b0;
    chk("flush_hs_wait", mul_rsp_ready_o, 1);
    mul_rsp_valid_i = 1'b1; mul_result_i = 32'h1234;
    step();
    mul_rsp_valid_i = 1'b0;
    chk("flush_hs_no_wb", wb_valid_o, 0);
    chk("flush_hs_idle", ex_ready_o, 1);

    // stray response in IDLE is ignored
    mul_rsp_valid_i = 1'b1; mul_result_i = 32'hDEADBEEF;
    step();
    mul_rsp_valid_i = 1'b0;
    chk("stray_no_wb", wb_valid_o, 0);
    chk("stray_data_kept", wb_data_o, 32'h1234);
    chk("stray_idle", ex_ready_o, 1);

    // asynchronous reset in WAIT, then a late response
    go_wait(2'b11, 32'hABCD0123, 32'h55AA55AA, 5'd12);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ex_ready", ex_ready_o, 1);
    chk("arst_rsp_ready", mul_rsp_ready_o, 0);
    chk("arst_mul_valid", mul_valid_o, 0);
    chk("arst_wb_valid", wb_valid_o, 0);
    chk("arst_mul_a", mul_a_o, 0);
    chk("arst_mul_b", mul_b_o, 0);
    chk("arst_mul_op", mul_op_o, 0);
    chk("arst_wb_rd", wb_rd_o, 0);
    chk("arst_wb_data", wb_data_o, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    mul_rsp_valid_i = 1'b1; mul_result_i = 32'd99;
    step();
    mul_rsp_valid_i = 1'b0;
    chk("late_rsp_no_wb", wb_valid_o, 0);
    chk("late_rsp_data", wb_data_o, 0);
    v = '{op: 2'b00, a: 32'd3, b: 32'd3, rd: 5'd7, rdy_dly: 0, rsp_dly: 0, exp: 32'd9};
    run_txn(v);

`ifdef MUL_REQ_TIMEOUT_EN
    go_wait(2'b00, 32'd4, 32'd4, 5'd8);
    for (int i = 1; i <= TO; i++) begin
      chk("to_in_wait", mul_rsp_ready_o, 1);
      chk("to_no_err_early", timeout_err_o, 0);
      step();
    end
    to_exp++;
    chk("to_err_pulse", timeout_err_o, 1);
    chk("to_idle", ex_ready_o, 1);
    chk("to_no_wb", wb_valid_o, 0);
    step();
    chk("to_err_one_cycle", timeout_err_o, 0);

    go_wait(2'b00, 32'd4, 32'd5, 5'd8);
    for (int i = 1; i < TO; i++) step();
    chk("to_edge_in_wait", mul_rsp_ready_o, 1);
    mul_rsp_valid_i = 1'b1; mul_result_i = 32'd20;
    step();
    mul_rsp_valid_i = 1'b0;
    wb_exp++;
    chk("to_edge_wb", wb_valid_o, 1);
    chk("to_edge_data", wb_data_o, 20);
    chk("to_edge_no_err", timeout_err_o, 0);
    step();
    chk("to_edge_no_err2", timeout_err_o, 0);
`else
    go_wait(2'b00, 32'd4, 32'd4, 5'd8);
    for (int i = 0; i < 40; i++) begin
      chk("nto_in_wait", mul_rsp_ready_o, 1);
      chk("nto_err_zero", timeout_err_o, 0);
      step();
    end
    mul_rsp_valid_i = 1'b1; mul_result_i = 32'd16;
    step();
    mul_rsp_valid_i = 1'b0;
    wb_exp++;
    chk("nto_wb", wb_valid_o, 1);
    chk("nto_data", wb_data_o, 16);
    step();
`endif

    step();
    chk("wb_pulse_count", wb_seen, wb_exp);
    chk("timeout_pulse_count", to_seen, to_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
